pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch stage of the 16-bit single-cycle datapath. It holds the program counter, addresses instruction memory, and registers each fetched instruction with its PC towards decode. It applies redirects from branches and register jumps. It sits directly upstream of the branch-offset shifter `sl1`, which it instantiates to turn a sign-extended word offset into a byte offset for the branch-target adder.

## Interface
Parameters:
- `PC_W`, 16, PC and instruction width.
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  16  byte address to instruction memory; combinational copy of PC.
- `imem_rdata`  in  16  instruction at `imem_addr`; combinational read, valid in the same cycle.
- `out_valid`  out  1  `out_instr`/`out_pc` hold a fetched instruction.
- `out_ready`  in  1  decode accepts the output this cycle.
- `out_instr`  out  16  registered instruction.
- `out_pc`  out  16  byte address of `out_instr`.
- `br_taken`  in  1  a taken conditional branch resolved this cycle.
- `br_pc`  in  16  PC of that branch.
- `br_offset`  in  16  sign-extended word offset.
- `jr_valid`  in  1  register jump this cycle.
- `jr_target`  in  16  jump address.
- `halt`  in  1  stop fetching; sticky until reset.

## Operation
- FSM in `pc_pkg::fetch_state_t`:
  - BOOT: one cycle after reset release, no fetch; goes to RUN.
  - RUN: normal fetch.
  - HALTED: terminal until reset.
- Branch target is `br_pc + 2 + sl1(br_offset)`, computed mod 2^16. Carry-out is discarded.
- Jump target is `{jr_target[15:1], 1'b0}`; bit 0 is forced to zero.
- In RUN, priority each cycle is as follows.
  1. `jr_valid`: PC <= jump target, `out_valid` <= 0 (squash).
  2. `br_taken`: PC <= branch target, `out_valid` <= 0.
  3. If `halt` is high: go to HALTED, PC held. `out_valid` <= 0 if the output is empty or `out_ready` is high; otherwise the held output is kept.
  4. If `!out_valid || out_ready`: `out_instr` <= `imem_rdata`, `out_pc` <= PC, `out_valid` <= 1, PC <= PC+2.
  5. Otherwise hold everything (backpressure).
- A redirect in the same cycle as `out_ready`=1 still drops the output. The held instruction is wrong-path.
- In HALTED: redirects are ignored, PC is frozen, and `out_valid` clears on the first `out_ready`.
- Wrap: PC 16'hFFFE + 2 -> 16'h0000, with no error.
- Reset values: PC=`RESET_PC`, `imem_addr`=`RESET_PC`, `out_valid`=0, `out_instr`=0, `out_pc`=0, state=BOOT.
- Reset mid-operation clears all state immediately, without waiting for a clock edge.

## Timing
- Fetch to output latency: 1 cycle. The instruction at PC appears on `out_*` after the edge that captures it.
- Sustained throughput: 1 instruction per cycle while `out_ready`=1.
- Redirect in cycle N:
  - `imem_addr` = target in cycle N+1.
  - `out_valid`=0 in cycle N+1.
  - The target instruction is valid in cycle N+2.
- While `out_valid`=1 and `out_ready`=0, the `out_*` outputs stay stable.
- `br_taken`, `jr_valid` and `halt` are sampled only on clock edges. Their level between edges has no effect.

## Structure
- `pc_pkg` holds:
  - `fetch_state_t` (BOOT, RUN, HALTED).
  - `localparam INSTR_BYTES = 2`.
  - `typedef logic [15:0] addr_t`.
- Sub-module: the existing `sl1`, instantiated once on `br_offset`.
- All other logic (adder, next-PC mux, output register, FSM) is inline.

## Test plan
- Reset release with `out_ready`=1 and memory returning the address as data:
  - BOOT cycle has `out_valid`=0.
  - Then `out_pc`/`out_instr` = 0000, 0002, 0004 on successive cycles.
- Backpressure: hold `out_ready`=0 for 3 cycles with `out_pc`=0004. The output stays 0004/0004 and PC stays 0006. On release, the next output is 0006.
- Forward branch: `br_pc`=0010, `br_offset`=000F, `br_taken`=1.
  - Next cycle: `imem_addr`=0030 and `out_valid`=0.
  - Following cycle: `out_pc`=0030.
- Backward branch: `br_pc`=0004, `br_offset`=FFFF -> target 0004.
  - Assert `jr_valid` (`jr_target`=0123) together with `br_taken` in the same cycle. The jump wins and PC becomes 0122.
- Wrap: `RESET_PC`=FFFC. Outputs are FFFC, FFFE, then 0000.
- Halt and reset:
  - `halt` with `out_ready`=1 -> `out_valid`=0 next cycle. PC is frozen and a later `br_taken` is ignored.
  - Dropping `reset_n` mid-cycle immediately clears `out_valid` and restores `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch FSM encoding (BOOT, RUN, HALTED)
//   INSTR_BYTES   : PC increment per sequential instruction
//   addr_t        : 16-bit byte address
package pc_pkg;

  localparam int unsigned INSTR_BYTES = 2;

  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sl1.sv
// Shift-left-by-one: converts a word offset into a byte offset.
//   a : input value
//   y : a << 1 (MSB discarded, LSB zero)
module sl1 #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = a << 1;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: program counter, instruction-memory addressing,
// registered instruction/PC towards decode, and branch/jump redirects.
//   clk, reset_n           : clock, async active-low reset
//   imem_addr / imem_rdata : instruction-memory address (PC) and read data
//   out_valid/out_ready    : handshake towards decode
//   out_instr / out_pc     : registered instruction and its byte address
//   br_taken/br_pc/br_offset : taken branch and its operands
//   jr_valid / jr_target   : register jump
//   halt                   : stop fetching, sticky until reset
module pc_fetch
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [PC_W-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_instr,
  output logic [PC_W-1:0] out_pc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_offset,
  input  logic            jr_valid,
  input  logic [PC_W-1:0] jr_target,
  input  logic            halt
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic            valid_nxt;
  logic [PC_W-1:0] instr_nxt, opc_nxt;
  logic [PC_W-1:0] br_byte_off;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jr_aligned;
  logic            can_load;

  // Word offset to byte offset for the branch-target adder.
  sl1 #(.W(PC_W)) u_sl1 (
    .a (br_offset),
    .y (br_byte_off)
  );

  // Targets wrap mod 2^PC_W; jump targets are forced halfword-aligned.
  assign br_target  = br_pc + PC_W'(INSTR_BYTES) + br_byte_off;
  assign jr_aligned = jr_target & ~PC_W'(1);

  assign imem_addr = pc;
  assign can_load  = !out_valid || out_ready;

  // Next-state and datapath selection.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = out_valid;
    instr_nxt = out_instr;
    opc_nxt   = out_pc;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (jr_valid) begin
          pc_nxt    = jr_aligned;
          valid_nxt = 1'b0;
        end else if (br_taken) begin
          pc_nxt    = br_target;
          valid_nxt = 1'b0;
        end else if (halt) begin
          state_nxt = HALTED;
          if (can_load) valid_nxt = 1'b0;
        end else if (can_load) begin
          instr_nxt = imem_rdata;
          opc_nxt   = pc;
          valid_nxt = 1'b1;
          pc_nxt    = pc + PC_W'(INSTR_BYTES);
        end
      end
      HALTED: begin
        // Drain the last held instruction, then stay idle until reset.
        if (out_ready) valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = BOOT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= BOOT;
    else          state <= state_nxt;
  end

  // PC and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      pc        <= pc_nxt;
      out_valid <= valid_nxt;
      out_instr <= instr_nxt;
      out_pc    <= opc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch. Memory returns its address as
// data. A second instance with RESET_PC=FFFC covers PC wrap-around.
module tb_pc_fetch;

  logic        clk;
  logic        reset_n;
  logic        out_ready;
  logic        br_taken;
  logic [15:0] br_pc;
  logic [15:0] br_offset;
  logic        jr_valid;
  logic [15:0] jr_target;
  logic        halt;

  logic [15:0] imem_addr, imem_rdata, out_instr, out_pc;
  logic        out_valid;
  logic [15:0] w_addr, w_rdata, w_instr, w_pc;
  logic        w_valid;

  int checks = 0;
  int errors = 0;

  assign imem_rdata = imem_addr;
  assign w_rdata    = w_addr;

  pc_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
    .jr_valid(jr_valid), .jr_target(jr_target), .halt(halt)
  );

  pc_fetch #(.PC_W(16), .RESET_PC(16'hFFFC)) dut_wrap (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(w_addr), .imem_rdata(w_rdata),
    .out_valid(w_valid), .out_ready(out_ready),
    .out_instr(w_instr), .out_pc(w_pc),
    .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
    .jr_valid(jr_valid), .jr_target(jr_target), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and stop at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    br_taken  = 1'b0;
    br_pc     = '0;
    br_offset = '0;
    jr_valid  = 1'b0;
    jr_target = '0;
    halt      = 1'b0;

    @(negedge clk);
    check("rst_valid", 16'(out_valid), 16'h0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_pc", out_pc, 16'h0000);
    check("rst_instr", out_instr, 16'h0000);
    check("rst_waddr", w_addr, 16'hFFFC);

    reset_n = 1'b1;
    step();  // BOOT cycle: nothing fetched
    check("boot_valid", 16'(out_valid), 16'h0);
    check("boot_addr", imem_addr, 16'h0000);

    step();
    check("f0_valid", 16'(out_valid), 16'h1);
    check("f0_pc", out_pc, 16'h0000);
    check("w0_pc", w_pc, 16'hFFFC);
    step();
    check("f1_pc", out_pc, 16'h0002);
    check("f1_instr", out_instr, 16'h0002);
    check("w1_pc", w_pc, 16'hFFFE);
    step();
    check("f2_pc", out_pc, 16'h0004);
    check("f2_instr", out_instr, 16'h0004);
    check("w2_pc", w_pc, 16'h0000);
    check("w2_instr", w_instr, 16'h0000);

    // Backpressure for three cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", 16'(out_valid), 16'h1);
      check("bp_pc", out_pc, 16'h0004);
      check("bp_instr", out_instr, 16'h0004);
      check("bp_addr", imem_addr, 16'h0006);
    end
    out_ready = 1'b1;
    step();
    check("rel_pc", out_pc, 16'h0006);

    // Forward branch: 0010 + 2 + 001E = 0030.
    br_pc = 16'h0010; br_offset = 16'h000F; br_taken = 1'b1;
    step();
    br_taken = 1'b0;
    check("fbr_addr", imem_addr, 16'h0030);
    check("fbr_valid", 16'(out_valid), 16'h0);
    step();
    check("fbr_pc", out_pc, 16'h0030);
    check("fbr_v2", 16'(out_valid), 16'h1);

    // Jump beats a simultaneous branch; bit 0 cleared.
    br_pc = 16'h0004; br_offset = 16'hFFFF; br_taken = 1'b1;
    jr_valid = 1'b1; jr_target = 16'h0123;
    step();
    jr_valid = 1'b0;
    check("jr_addr", imem_addr, 16'h0122);
    check("jr_valid", 16'(out_valid), 16'h0);
    // Backward branch alone: 0004 + 2 - 2 = 0004.
    step();
    br_taken = 1'b0;
    check("bbr_addr", imem_addr, 16'h0004);
    check("bbr_valid", 16'(out_valid), 16'h0);
    step();
    check("bbr_pc", out_pc, 16'h0004);

    // Redirect while output is stalled still squashes it.
    out_ready = 1'b0;
    step();
    check("stall_pc", out_pc, 16'h0004);
    jr_valid = 1'b1; jr_target = 16'h0041;
    step();
    jr_valid = 1'b0;
    check("sq_valid", 16'(out_valid), 16'h0);
    check("sq_addr", imem_addr, 16'h0040);
    out_ready = 1'b1;
    step();
    check("sq_pc", out_pc, 16'h0040);

    // Halt with ready: output clears, PC frozen, redirects ignored.
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_valid", 16'(out_valid), 16'h0);
    check("halt_addr", imem_addr, 16'h0042);
    br_pc = 16'h0010; br_offset = 16'h000F; br_taken = 1'b1;
    step();
    step();
    br_taken = 1'b0;
    check("halt_br_addr", imem_addr, 16'h0042);
    check("halt_br_valid", 16'(out_valid), 16'h0);

    // Asynchronous reset mid-cycle.
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 16'(out_valid), 16'h0);
    check("arst_addr", imem_addr, 16'h0000);
    check("arst_pc", out_pc, 16'h0000);
    check("arst_waddr", w_addr, 16'hFFFC);
    @(negedge clk);
    reset_n = 1'b1;

    // Halt under backpressure keeps the held output until ready.
    step();  // BOOT
    step();  // fetch 0000
    check("h2_pc", out_pc, 16'h0000);
    out_ready = 1'b0; halt = 1'b1;
    step();
    halt = 1'b0;
    check("h2_hold_valid", 16'(out_valid), 16'h1);
    check("h2_hold_pc", out_pc, 16'h0000);
    check("h2_addr", imem_addr, 16'h0002);
    out_ready = 1'b1;
    step();
    check("h2_drain_valid", 16'(out_valid), 16'h0);
    check("h2_drain_addr", imem_addr, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
